router_pkt_fifo: RTL and testbench

Parametrised packet-aware FIFO for the router datapath, the next generation of the fixed 8-bit × 16 router FIFO. It stores header-tagged words, tracks packet boundaries on the read side from the header length field, and reports fill level, packet start/end and sticky error flags. One instance sits between the router FSM/register stage and each output port.

---
 rtl/router_pkt_fifo_if.sv | 44 ++++
 rtl/router_pkt_fifo.sv | 139 +++++++++++++
 tb/tb_router_pkt_fifo.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_fifo_if.sv
// router_pkt_fifo_if
// Bundles the write side, read side, level flags and sticky error flags of
// router_pkt_fifo.
//   master : drives write_enb, lfd_state, data_in and read_enb;
//            observes data_out, data_valid, sop_out, eop_out, level flags,
//            count and error flags.
//   slave  : the FIFO side, with the directions reversed.
interface router_pkt_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              write_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic              read_enb;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              sop_out;
  logic              eop_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;
  logic              framing_err;

  modport master (
    output write_enb, lfd_state, data_in, read_enb,
    input  data_out, data_valid, sop_out, eop_out,
    input  full, empty, almost_full, almost_empty, count,
    input  overflow, underflow, framing_err
  );

  modport slave (
    input  write_enb, lfd_state, data_in, read_enb,
    output data_out, data_valid, sop_out, eop_out,
    output full, empty, almost_full, almost_empty, count,
    output overflow, underflow, framing_err
  );
endinterface

// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo
// Packet-aware FIFO between the router register stage and an output port.
// Each stored word carries a header tag (lfd_state at write time). On the read
// side the header length field drives a remaining-word counter so the FIFO can
// flag the first (sop_out) and last/parity (eop_out) word of each packet and
// detect framing errors.
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous active-high full clear (including sticky errors)
//   soft_reset : synchronous active-high flush; sticky errors are kept
//   bus        : router_pkt_fifo_if.slave -- write/read requests, registered
//                read data with valid/sop/eop, level flags, count, errors
module router_pkt_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int LEN_LSB  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               soft_reset,
  router_pkt_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = DATA_W - LEN_LSB;
  localparam int RW = LW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [RW-1:0]     remaining;

  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic              sop_p1;
  logic              eop_p1;
  logic              overflow_q;
  logic              underflow_q;
  logic              framing_q;

  logic              full_w;
  logic              empty_w;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W:0]   rd_word;
  logic [LW-1:0]     rd_len;

  assign full_w  = (count == DEPTH_C);
  assign empty_w = (count == '0);

  // A flush or reset cycle ignores both requests.
  assign wr_acc = bus.write_enb && !full_w  && !reset && !soft_reset;
  assign rd_acc = bus.read_enb  && !empty_w && !reset && !soft_reset;

  assign rd_word = mem[rd_ptr];
  assign rd_len  = rd_word[DATA_W-1:LEN_LSB];

  // Storage: no reset, only the pointers define valid contents.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= {bus.lfd_state, bus.data_in};
  end

  // Stage p0 -> p1: pointer/count update, pop, packet tracking.
  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
      data_p1   <= '0;
      vld_p1    <= 1'b0;
      sop_p1    <= 1'b0;
      eop_p1    <= 1'b0;
      if (reset) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
        framing_q   <= 1'b0;
      end
    end else begin
      if (bus.write_enb && full_w) overflow_q  <= 1'b1;
      if (bus.read_enb && empty_w) underflow_q <= 1'b1;

      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (rd_acc) begin
        rd_ptr  <= rd_ptr + AW'(1);
        data_p1 <= rd_word[DATA_W-1:0];
        vld_p1  <= 1'b1;
        sop_p1  <= rd_word[DATA_W];
        eop_p1  <= 1'b0;
        if (rd_word[DATA_W]) begin
          // A header always restarts the packet, even if the previous one
          // was cut short; the truncation is recorded as a framing error.
          remaining <= {1'b0, rd_len} + RW'(1);
          if (remaining != '0) framing_q <= 1'b1;
        end else if (remaining > RW'(1)) begin
          remaining <= remaining - RW'(1);
        end else if (remaining == RW'(1)) begin
          remaining <= '0;
          eop_p1    <= 1'b1;
        end else begin
          framing_q <= 1'b1;
        end
      end else begin
        data_p1 <= '0;
        vld_p1  <= 1'b0;
        sop_p1  <= 1'b0;
        eop_p1  <= 1'b0;
      end
    end
  end

  // Stage p1: registered outputs and count-derived flags.
  assign bus.data_out     = data_p1;
  assign bus.data_valid   = vld_p1;
  assign bus.sop_out      = sop_p1;
  assign bus.eop_out      = eop_p1;
  assign bus.count        = count;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count >= AF_C);
  assign bus.almost_empty = (count <= AE_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.framing_err  = framing_q;
endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb_router_pkt_fifo
// Directed bench for router_pkt_fifo (DATA_W=8, DEPTH=16). A queue-based
// reference model tracks stored words, packet position and sticky flags; a
// negedge process compares every DUT output against it each cycle, and the
// stimulus sequence adds hand-computed literal expectations.
module tb_router_pkt_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clock = 1'b0;
  logic reset;
  logic soft_reset;

  router_pkt_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  router_pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {tag,data}, an integer remaining-word count.
  logic [8:0] q[$];
  int         m_rem;
  logic [7:0] m_data;
  bit         m_vld, m_sop, m_eop, m_ovf, m_udf, m_ferr;

  always @(posedge clock) begin
    if (reset || soft_reset) begin
      q.delete();
      m_rem = 0; m_data = 8'h00; m_vld = 0; m_sop = 0; m_eop = 0;
      if (reset) begin m_ovf = 0; m_udf = 0; m_ferr = 0; end
    end else begin
      bit can_w, can_r;
      logic [8:0] w;
      can_w = bus.write_enb && (q.size() < DEPTH);
      can_r = bus.read_enb && (q.size() > 0);
      if (bus.write_enb && !can_w) m_ovf = 1;
      if (bus.read_enb && !can_r)  m_udf = 1;
      if (can_r) begin
        w = q.pop_front();
        m_data = w[7:0]; m_vld = 1; m_sop = w[8]; m_eop = 0;
        if (w[8]) begin
          if (m_rem != 0) m_ferr = 1;
          m_rem = int'(w[7:2]) + 1;
        end else if (m_rem == 0) begin
          m_ferr = 1;
        end else begin
          m_rem = m_rem - 1;
          if (m_rem == 0) m_eop = 1;
        end
      end else begin
        m_data = 8'h00; m_vld = 0; m_sop = 0; m_eop = 0;
      end
      if (can_w) q.push_back({bus.lfd_state, bus.data_in});
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      check("m_data_out",    bus.data_out,     m_data);
      check("m_data_valid",  bus.data_valid,   m_vld);
      check("m_sop_out",     bus.sop_out,      m_sop);
      check("m_eop_out",     bus.eop_out,      m_eop);
      check("m_count",       bus.count,        q.size());
      check("m_full",        bus.full,         q.size() == DEPTH);
      check("m_empty",       bus.empty,        q.size() == 0);
      check("m_almost_full", bus.almost_full,  q.size() >= DEPTH - 2);
      check("m_almost_empty",bus.almost_empty, q.size() <= 2);
      check("m_overflow",    bus.overflow,     m_ovf);
      check("m_underflow",   bus.underflow,    m_udf);
      check("m_framing_err", bus.framing_err,  m_ferr);
    end
  end

  task automatic drive(input logic we, input logic lfd, input logic [7:0] d, input logic re);
    bus.write_enb = we;
    bus.lfd_state = lfd;
    bus.data_in   = d;
    bus.read_enb  = re;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 8'h00, 0);
    reset = 1'b0;
  endtask

  logic [7:0] pkt_a [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    reset = 1'b1;
    soft_reset = 1'b0;
    bus.write_enb = 0; bus.lfd_state = 0; bus.data_in = 0; bus.read_enb = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_en = 1'b1;

    // Reset state
    drive(0, 0, 8'h00, 0);
    check("rst_data_out", bus.data_out, 8'h00);
    check("rst_empty", bus.empty, 1);
    check("rst_count", bus.count, 0);
    check("rst_errors", {bus.overflow, bus.underflow, bus.framing_err}, 3'b000);
    check("rst_almost_empty", bus.almost_empty, 1);
    check("rst_full", {bus.full, bus.almost_full}, 2'b00);

    // Single packet: header len 3, three payload words, parity
    for (int i = 0; i < 5; i++) drive(1, i == 0, pkt_a[i], 0);
    check("pkt_count5", bus.count, 5);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 8'h00, 1);
      check("pkt_data", bus.data_out, pkt_a[i]);
      check("pkt_valid", bus.data_valid, 1);
      check("pkt_sop", bus.sop_out, i == 0);
      check("pkt_eop", bus.eop_out, i == 4);
      check("pkt_count", bus.count, 4 - i);
    end
    drive(0, 0, 8'h00, 0);
    check("pkt_valid_drop", bus.data_valid, 0);

    // Fill and wrap: header len 14 then 15 words makes exactly 16 entries
    for (int i = 0; i < 16; i++) begin
      drive(1, i == 0, (i == 0) ? 8'h38 : 8'(8'h40 + i - 1), 0);
      check("fill_af", bus.almost_full, (i + 1) >= 14);
    end
    check("fill_full", bus.full, 1);
    check("fill_ovf0", bus.overflow, 0);
    drive(1, 0, 8'hEE, 0);
    check("fill_ovf", bus.overflow, 1);
    check("fill_count16", bus.count, 16);
    repeat (8) drive(0, 0, 8'h00, 1);
    check("wrap_mid_data", bus.data_out, 8'h46);
    for (int i = 0; i < 8; i++) drive(1, i == 0, (i == 0) ? 8'h18 : 8'(8'h60 + i - 1), 0);
    check("wrap_full", bus.full, 1);
    for (int i = 0; i < 16; i++) drive(0, 0, 8'h00, 1);
    check("wrap_last", bus.data_out, 8'h66);
    check("wrap_last_eop", bus.eop_out, 1);
    check("wrap_empty", bus.empty, 1);

    // Simultaneous read/write at count 5: header len 7 plus four payload
    drive(1, 1, 8'h1C, 0);
    for (int i = 1; i < 5; i++) drive(1, 0, 8'(i), 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 8'(8'h05 + i), 1);
      check("sim_count", bus.count, 5);
      check("sim_data", bus.data_out, (i == 0) ? 8'h1C : 8'(i));
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 8'h00, 1);
      check("sim_tail", bus.data_out, 8'(8'h04 + i));
    end
    check("sim_eop", bus.eop_out, 1);
    check("udf0", bus.underflow, 0);
    drive(0, 0, 8'h00, 1);
    check("udf_set", bus.underflow, 1);
    check("udf_valid", bus.data_valid, 0);

    // Framing: orphan word
    do_reset();
    check("frm_clear", bus.framing_err, 0);
    drive(1, 0, 8'h55, 0);
    drive(0, 0, 8'h00, 1);
    check("frm_orphan_data", bus.data_out, 8'h55);
    check("frm_orphan", bus.framing_err, 1);

    // Framing: header arrives with one payload word still owed
    do_reset();
    drive(1, 1, 8'h08, 0);
    drive(1, 0, 8'hA1, 0);
    drive(1, 1, 8'h04, 0);
    drive(1, 0, 8'hB1, 0);
    drive(1, 0, 8'hB2, 0);
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 1);
    check("frm_early", bus.framing_err, 0);
    drive(0, 0, 8'h00, 1);
    check("frm_hdr_sop", bus.sop_out, 1);
    check("frm_hdr", bus.framing_err, 1);
    drive(0, 0, 8'h00, 1);
    check("frm_new_len_mid", bus.eop_out, 0);
    drive(0, 0, 8'h00, 1);
    check("frm_new_len_eop", bus.eop_out, 1);

    // soft_reset mid-packet, sticky underflow preserved, no stale remaining
    do_reset();
    drive(0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) drive(1, i == 0, pkt_a[i], 0);
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 1);
    soft_reset = 1'b1;
    drive(1, 1, 8'h99, 1);
    soft_reset = 1'b0;
    check("sr_count", bus.count, 0);
    check("sr_empty", bus.empty, 1);
    check("sr_valid", bus.data_valid, 0);
    check("sr_udf_kept", bus.underflow, 1);
    drive(1, 1, 8'h04, 0);
    drive(1, 0, 8'hC1, 0);
    drive(1, 0, 8'hC2, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00, 1);
      check("sr_sop", bus.sop_out, i == 0);
      check("sr_eop", bus.eop_out, i == 2);
    end
    check("sr_no_frm", bus.framing_err, 0);
    drive(0, 0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
